// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared definitions for the memory-access stage:
//   - funct3 load/store size encodings
//   - LSU bus FSM state encodings
//   - helpers that decode the access size and detect misaligned addresses
// Undefined funct3 values (011, 11x) decode as word accesses.
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  function automatic lsu_size_e access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (access_size(f3))
      SZ_H:    return a[0];
      SZ_W:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// lsu_load_align
// Combinational load-data alignment: picks the byte/half lane addressed by
// addr_lo out of the 32-bit read word and sign- or zero-extends it.
// Ports:
//   rdata   in  32  read word as returned by the bus
//   addr_lo in  2   low address bits of the access
//   funct3  in  3   access size/sign (bit 2 set = unsigned)
//   data    out 32  aligned, extended load value
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[addr_lo];
    // Half accesses ignore addr_lo[0]; the lane is chosen by bit 1 only.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sign_ext = ~funct3[2];
    case (access_size(funct3))
      SZ_B:    data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory-access stage of the 5-stage RV32 core. Registers the execute-stage
// outputs, runs loads/stores over a request/response data bus (stalling the
// upstream stages while a transaction is in flight) and presents write-back
// data and control.
// Optional feature: define LSU_MISALIGN_CHECK_EN to suppress misaligned
// half/word accesses and expose the misalign flag.
// Ports:
//   clk, rst_n (sync, active-low)
//   inst_clear                    flush of the instruction being captured
//   pc, ex_result, rs2_value, funct3, rd, csrs, csr_wen, R_wen,
//   mem_wen, mem_ren              execute-stage outputs
//   stall_req                     hold upstream stages
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb  bus request
//   rsp_valid/rsp_rdata           bus response / write acknowledge
//   wb_data, rd_next, R_wen_next, csr_wen_next, csrs_next, pc_next
//                                 write-back outputs
//   misalign                      misaligned flag (feature builds only)
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_clear,
  input  logic [31:0]           pc,
  input  logic [31:0]           ex_result,
  input  logic [DATA_W-1:0]     rs2_value,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd,
  input  logic [31:0]           csrs,
  input  logic [3:0]            csr_wen,
  input  logic                  R_wen,
  input  logic                  mem_wen,
  input  logic                  mem_ren,
  output logic                  stall_req,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W-1:0]     req_wdata,
  output logic [DATA_W/8-1:0]   req_wstrb,
  input  logic                  rsp_valid,
  input  logic [DATA_W-1:0]     rsp_rdata,
  output logic [31:0]           wb_data,
  output logic [4:0]            rd_next,
  output logic                  R_wen_next,
  output logic [3:0]            csr_wen_next,
  output logic [31:0]           csrs_next,
  output logic [31:0]           pc_next
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                  misalign
`endif
);

  localparam int STRB_W = DATA_W / 8;

  lsu_state_e        state_q;
  logic              stall_q;
  logic              req_valid_q;
  logic [31:0]       pc_q;
  logic [31:0]       ex_result_q;
  logic [DATA_W-1:0] rs2_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [31:0]       csrs_q;
  logic [3:0]        csr_wen_q;
  logic              r_wen_q;
  logic              mem_wen_q;
  logic              mem_ren_q;
  logic [DATA_W-1:0] rdata_q;

  logic              cap_mem;
  logic              cap_mis;
  logic              held_mis;
  lsu_size_e         size_q;
  logic [STRB_W-1:0] strb;
  logic [31:0]       load_data;

  assign cap_mem = ~inst_clear & (mem_wen | mem_ren);

`ifdef LSU_MISALIGN_CHECK_EN
  assign cap_mis  = is_misaligned(funct3, ex_result[1:0]);
  assign held_mis = (mem_wen_q | mem_ren_q) & is_misaligned(funct3_q, ex_result_q[1:0]);
  assign misalign = held_mis;
`else
  assign cap_mis  = 1'b0;
  assign held_mis = 1'b0;
`endif

  // Capture happens only in IDLE, which is exactly when stall_req is low.
  // stall_req and req_valid are kept as registered copies of the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      stall_q     <= 1'b0;
      req_valid_q <= 1'b0;
      pc_q        <= '0;
      ex_result_q <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      csrs_q      <= '0;
      csr_wen_q   <= '0;
      r_wen_q     <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pc_q        <= pc;
          ex_result_q <= ex_result;
          rs2_q       <= rs2_value;
          funct3_q    <= funct3;
          rd_q        <= rd;
          csrs_q      <= csrs;
          csr_wen_q   <= inst_clear ? 4'b0 : csr_wen;
          r_wen_q     <= R_wen & ~inst_clear;
          mem_wen_q   <= mem_wen & ~inst_clear;
          mem_ren_q   <= mem_ren & ~inst_clear;
          if (cap_mem && !cap_mis) begin
            state_q     <= ST_REQ;
            stall_q     <= 1'b1;
            req_valid_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            state_q     <= ST_RESP;
            req_valid_q <= 1'b0;
          end
        end
        ST_RESP: begin
          // Responses are only meaningful here; strays in other states are dropped.
          if (rsp_valid) begin
            rdata_q <= rsp_rdata;
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          stall_q     <= 1'b0;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign size_q = access_size(funct3_q);

  // Store lane replication: byte stores copy the byte to every lane, half
  // stores copy the half to both halves, words pass straight through.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wlane
    assign req_wdata[8*gi +: 8] = (size_q == SZ_B) ? rs2_q[7:0] :
                                  (size_q == SZ_H) ? rs2_q[8*(gi%2) +: 8] :
                                                     rs2_q[8*gi +: 8];
  end

  always_comb begin
    case (size_q)
      SZ_B:    strb = 4'b0001 << ex_result_q[1:0];
      SZ_H:    strb = 4'b0011 << {ex_result_q[1], 1'b0};
      default: strb = 4'b1111;
    endcase
  end

  // Strobes are only meaningful for stores; keeping them at zero otherwise
  // also keeps every output at zero out of reset.
  assign req_wstrb = mem_wen_q ? strb : '0;

  lsu_load_align u_load_align (
    .rdata   (rdata_q),
    .addr_lo (ex_result_q[1:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  assign stall_req    = stall_q;
  assign req_valid    = req_valid_q;
  assign req_we       = mem_wen_q;
  assign req_addr     = {ex_result_q[ADDR_W-1:2], 2'b00};
  assign wb_data      = mem_ren_q ? load_data : ex_result_q;
  assign rd_next      = rd_q;
  assign R_wen_next   = r_wen_q & ~stall_q & ~held_mis;
  assign csr_wen_next = stall_q ? 4'b0 : csr_wen_q;
  assign csrs_next    = csrs_q;
  assign pc_next      = pc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Randomized and directed stimulus for mem_stage_lsu, checked against a
// transaction-level reference model (load/store lane arithmetic, expected
// stall length) kept in this file. Build with LSU_MISALIGN_CHECK_EN defined
// to exercise the misalignment feature.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_clear;
  logic [31:0] pc;
  logic [31:0] ex_result;
  logic [31:0] rs2_value;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] csrs;
  logic [3:0]  csr_wen;
  logic        R_wen;
  logic        mem_wen;
  logic        mem_ren;
  logic        stall_req;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] wb_data;
  logic [4:0]  rd_next;
  logic        R_wen_next;
  logic [3:0]  csr_wen_next;
  logic [31:0] csrs_next;
  logic [31:0] pc_next;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (stall_req) stall_cnt++;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_clear   (inst_clear),
    .pc           (pc),
    .ex_result    (ex_result),
    .rs2_value    (rs2_value),
    .funct3       (funct3),
    .rd           (rd),
    .csrs         (csrs),
    .csr_wen      (csr_wen),
    .R_wen        (R_wen),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .stall_req    (stall_req),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .wb_data      (wb_data),
    .rd_next      (rd_next),
    .R_wen_next   (R_wen_next),
    .csr_wen_next (csr_wen_next),
    .csrs_next    (csrs_next),
    .pc_next      (pc_next)
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random junk on the upstream lines; must be ignored while stalled.
  task automatic scramble();
    pc         = $urandom;
    ex_result  = $urandom;
    rs2_value  = $urandom;
    funct3     = 3'($urandom);
    rd         = 5'($urandom);
    csrs       = $urandom;
    csr_wen    = 4'($urandom);
    R_wen      = 1'($urandom);
    mem_wen    = 1'($urandom);
    mem_ren    = 1'($urandom);
    inst_clear = 1'($urandom);
  endtask

  task automatic bubble();
    pc = 0; ex_result = 0; rs2_value = 0; funct3 = 0; rd = 0; csrs = 0;
    csr_wen = 0; R_wen = 0; mem_wen = 0; mem_ren = 0; inst_clear = 0;
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      off = (off / 2) * 2;
      v = (d >> (8 * off)) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic void store_model(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd, output logic [31:0] wdat,
                                      output logic [3:0] strb);
    int unsigned off;
    off = a % 4;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      wdat = (wd & 32'hFF) * 32'h0101_0101;
      strb = 4'(1 << off);
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      wdat = (wd & 32'hFFFF) * 32'h0001_0001;
      strb = 4'(3 << ((off / 2) * 2));
    end else begin
      wdat = wd;
      strb = 4'hF;
    end
  endfunction

  function automatic logic mis_model(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"},   32'(stall_req),    0);
    chk({tag, "_rvalid"},  32'(req_valid),    0);
    chk({tag, "_we"},      32'(req_we),       0);
    chk({tag, "_addr"},    req_addr,          0);
    chk({tag, "_wdata"},   req_wdata,         0);
    chk({tag, "_wstrb"},   32'(req_wstrb),    0);
    chk({tag, "_wb"},      wb_data,           0);
    chk({tag, "_rd"},      32'(rd_next),      0);
    chk({tag, "_rwen"},    32'(R_wen_next),   0);
    chk({tag, "_cwen"},    32'(csr_wen_next), 0);
    chk({tag, "_csrs"},    csrs_next,         0);
    chk({tag, "_pc"},      pc_next,           0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk({tag, "_mis"},     32'(misalign),     0);
`endif
  endtask

  // One instruction from capture to its write-back cycle. Entered and left
  // one time unit after a rising edge with the stage idle.
  task automatic run_op(input logic [2:0] f3, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int rdy_dly, input int rsp_dly,
                        input logic clr, input logic rw, input logic [3:0] cw);
    logic [31:0] p, cs, exp_wdat;
    logic [4:0]  r;
    logic [3:0]  exp_strb;
    logic        mem, mis;
    int          cnt0, exp_stalls;
    p  = $urandom;
    cs = $urandom;
    r  = 5'($urandom);
    store_model(f3, addr, wd, exp_wdat, exp_strb);
    mem = !clr && (ld || st);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = mem && mis_model(f3, addr);
`endif
    exp_stalls = (mem && !mis) ? rdy_dly + rsp_dly + 2 : 0;

    chk("pre_stall", 32'(stall_req), 0);
    pc = p; ex_result = addr; rs2_value = wd; funct3 = f3; rd = r; csrs = cs;
    csr_wen = cw; R_wen = rw; mem_wen = st; mem_ren = ld; inst_clear = clr;
    req_ready = 1'b0; rsp_valid = 1'b0;
    cnt0 = stall_cnt;
    step();
    scramble();

    if (mem && !mis) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("req_valid", 32'(req_valid),    1);
        chk("req_stall", 32'(stall_req),    1);
        chk("req_addr",  req_addr,          addr & 32'hFFFF_FFFC);
        chk("req_we",    32'(req_we),       32'(st));
        chk("req_rwen",  32'(R_wen_next),   0);
        chk("req_cwen",  32'(csr_wen_next), 0);
        if (st) begin
          chk("req_wdata", req_wdata,       exp_wdat);
          chk("req_wstrb", 32'(req_wstrb),  32'(exp_strb));
        end
        req_ready = (i == rdy_dly);
        rsp_valid = 1'($urandom);   // stray, must be ignored in REQ
        rsp_rdata = $urandom;
        step();
        scramble();
      end
      req_ready = 1'b0;
      for (int j = 0; j <= rsp_dly; j++) begin
        chk("resp_valid", 32'(req_valid),    0);
        chk("resp_stall", 32'(stall_req),    1);
        chk("resp_rwen",  32'(R_wen_next),   0);
        chk("resp_cwen",  32'(csr_wen_next), 0);
        rsp_valid = (j == rsp_dly);
        rsp_rdata = (j == rsp_dly) ? rdat : $urandom;
        step();
        scramble();
      end
      rsp_valid = 1'b0;
    end

    chk("out_stall",  32'(stall_req),    0);
    chk("out_rvalid", 32'(req_valid),    0);
    chk("stall_len",  32'(stall_cnt - cnt0), 32'(exp_stalls));
    chk("out_rd",     32'(rd_next),      32'(r));
    chk("out_pc",     pc_next,           p);
    chk("out_csrs",   csrs_next,         cs);
    chk("out_cwen",   32'(csr_wen_next), clr ? 32'd0 : 32'(cw));
    chk("out_rwen",   32'(R_wen_next),   32'(rw && !clr && !mis));
    if (!mis)
      chk("out_wb", wb_data, (ld && !clr) ? load_model(f3, addr, rdat) : addr);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("out_mis", 32'(misalign), 32'(mis));
`endif
    $display("txn %0d f3=%0d ld=%0d st=%0d clr=%0d addr=0x%08h wb=0x%08h stalls=%0d errors=%0d",
             txn, f3, ld, st, clr, addr, wb_data, stall_cnt - cnt0, errors);
    txn++;
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'hDEAD_BEEF;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed cases
    run_op(3'b000, 1'b0, 1'b1, 32'h0000_1003, 32'h1234_56AB, 32'h0, 0, 0, 1'b0, 1'b0, 4'h0);
    run_op(3'b001, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7F00, 0, 0, 1'b0, 1'b1, 4'h0);
    run_op(3'b101, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7F00, 0, 0, 1'b0, 1'b1, 4'h0);
    run_op(3'b010, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b0, 1'b1, 4'h0);
    run_op(3'b000, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 0, 0, 1'b1, 1'b1, 4'hA);
    run_op(3'b000, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 4'h3);
    run_op(3'b010, 1'b1, 1'b0, 32'h0000_3002, 32'h0, 32'h1357_9BDF, 1, 0, 1'b0, 1'b1, 4'h0);
    run_op(3'b001, 1'b0, 1'b1, 32'h0000_1001, 32'hA5A5_5A5A, 32'h0, 0, 1, 1'b0, 1'b0, 4'h0);
    run_op(3'b110, 1'b1, 1'b0, 32'h0000_4004, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b1, 4'h0);

    // Randomized mix of ALU, load and store instructions
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [2:0]  f3;
      logic        clr;
      kind = $urandom_range(2, 0);
      clr  = ($urandom_range(5, 0) == 0);
      if (kind == 2) begin
        f3 = 3'($urandom_range(2, 0));
        run_op(f3, 1'b0, 1'b1, $urandom, $urandom, 32'h0,
               $urandom_range(3, 0), $urandom_range(3, 0), clr, 1'b0, 4'($urandom));
      end else if (kind == 1) begin
        f3 = 3'($urandom);
        run_op(f3, 1'b1, 1'b0, $urandom, $urandom, $urandom,
               $urandom_range(3, 0), $urandom_range(3, 0), clr, 1'($urandom), 4'($urandom));
      end else begin
        f3 = 3'($urandom);
        run_op(f3, 1'b0, 1'b0, $urandom, $urandom, $urandom,
               0, 0, clr, 1'($urandom), 4'($urandom));
      end
    end

    // Reset in the middle of a load, then a stray response
    bubble();
    funct3 = 3'b010; ex_result = 32'h0000_4000; mem_ren = 1'b1; R_wen = 1'b1; rd = 5'd7;
    step();
    bubble();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("rst_mid_stall", 32'(stall_req), 1);
    chk("rst_mid_rvalid", 32'(req_valid), 0);
    rst_n = 1'b0;
    step();
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hFFFF_FFFF;
    step();
    rsp_valid = 1'b0;
    chk("stray_stall", 32'(stall_req), 0);
    chk("stray_rvalid", 32'(req_valid), 0);
    chk("stray_wb", wb_data, 0);
    step();
    chk("stray_stall2", 32'(stall_req), 0);
    run_op(3'b100, 1'b1, 1'b0, 32'h0000_5001, 32'h0, 32'h0000_C300, 0, 0, 1'b0, 1'b1, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
